// File: rtl/clock_divider_multi.sv
// clock_divider_multi: multi-channel programmable clock divider.
// Each channel divides clk by 2*div with 50% duty and a one-cycle tick
// on every rising edge of its output. Divisors are written through a
// shared port and take effect only at half-period boundaries, so an
// output never produces a runt pulse.
// Optional feature: define CLKDIV_PHASE_SYNC_EN to add the 'sync' input,
// which restarts every enabled channel in phase and applies pending divisors.
module clock_divider_multi #(
    parameter int CHANNELS    = 2,
    parameter int WIDTH       = 32,
    parameter int DEFAULT_DIV = 500000,
    localparam int CH_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CHANNELS-1:0] en,
    input  logic                wr_en,
    input  logic [CH_W-1:0]     wr_ch,
    input  logic [WIDTH-1:0]    wr_data,
`ifdef CLKDIV_PHASE_SYNC_EN
    input  logic                sync,
`endif
    output logic                wr_err,
    output logic [CHANNELS-1:0] clk_out,
    output logic [CHANNELS-1:0] tick,
    output logic [CHANNELS-1:0] pending
);

    logic [WIDTH-1:0]    div_q      [CHANNELS];
    logic [WIDTH-1:0]    cnt_q      [CHANNELS];
    logic [WIDTH-1:0]    pend_div_q [CHANNELS];
    logic                wr_ok;
    logic [CHANNELS-1:0] wr_hit;
    logic [CHANNELS-1:0] boundary;
    logic                sync_req;

`ifdef CLKDIV_PHASE_SYNC_EN
    assign sync_req = sync;
`else
    assign sync_req = 1'b0;
`endif

    // A write is legal only for an existing channel and a non-zero divisor.
    assign wr_ok = (32'(wr_ch) < 32'(CHANNELS)) && (wr_data != '0);

    // Decode the write target and detect the last cycle of each half-period.
    always_comb begin
        // NOTE: defaults first so every path assigns every bit and no latch is inferred.
        wr_hit   = '0;
        boundary = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            wr_hit[i]   = wr_en && wr_ok && (wr_ch == CH_W'(i));
            boundary[i] = (cnt_q[i] == div_q[i] - WIDTH'(1));
        end
    end

    // Rejected writes are flagged for exactly one cycle after the strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: sequential state uses non-blocking assignments so all flops update together.
            wr_err <= 1'b0;
        end else begin
            wr_err <= wr_en && !wr_ok;
        end
    end

    // Per-channel counter, output toggle, tick and glitch-free divisor update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the divisor arrays are small register files, so they take the
            // async reset like any other state and the channels restart deterministically.
            for (int i = 0; i < CHANNELS; i++) begin
                div_q[i]      <= WIDTH'(DEFAULT_DIV);
                cnt_q[i]      <= '0;
                pend_div_q[i] <= '0;
            end
            clk_out <= '0;
            tick    <= '0;
            pending <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (!en[i] || sync_req) begin
                    // Stopped or phase-resynchronised: no half-period is in
                    // progress, so a new divisor may be taken immediately.
                    cnt_q[i]   <= '0;
                    clk_out[i] <= 1'b0;
                    tick[i]    <= 1'b0;
                    if (wr_hit[i]) begin
                        div_q[i] <= wr_data;
                    end else if (pending[i]) begin
                        div_q[i] <= pend_div_q[i];
                    end
                    pending[i] <= 1'b0;
                end else if (boundary[i]) begin
                    // Half-period complete: toggle and switch divisor here.
                    cnt_q[i]   <= '0;
                    clk_out[i] <= ~clk_out[i];
                    tick[i]    <= ~clk_out[i];
                    if (wr_hit[i]) begin
                        div_q[i] <= wr_data;
                    end else if (pending[i]) begin
                        div_q[i] <= pend_div_q[i];
                    end
                    pending[i] <= 1'b0;
                end else begin
                    // Mid half-period: park a written divisor until the boundary.
                    cnt_q[i] <= cnt_q[i] + WIDTH'(1);
                    tick[i]  <= 1'b0;
                    if (wr_hit[i]) begin
                        pend_div_q[i] <= wr_data;
                        pending[i]    <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_clock_divider_multi.sv
// tb_clock_divider_multi: randomized bench with a behavioural model of the
// divider (half-period countdown per channel) compared every cycle, plus
// directed scenarios with hand-computed timings.
module tb_clock_divider_multi;

    localparam int CHANNELS    = 3;
    localparam int WIDTH       = 16;
    localparam int DEFAULT_DIV = 4;
    localparam int CH_W        = 2;
    localparam int BUDGET      = 100;

    logic                clk     = 1'b0;
    logic                rst_n   = 1'b0;
    logic [CHANNELS-1:0] en      = '0;
    logic                wr_en   = 1'b0;
    logic [CH_W-1:0]     wr_ch   = '0;
    logic [WIDTH-1:0]    wr_data = '0;
`ifdef CLKDIV_PHASE_SYNC_EN
    logic                sync    = 1'b0;
`endif
    logic                wr_err;
    logic [CHANNELS-1:0] clk_out;
    logic [CHANNELS-1:0] tick;
    logic [CHANNELS-1:0] pending;

    int errors = 0;
    int checks = 0;

    clock_divider_multi #(
        .CHANNELS   (CHANNELS),
        .WIDTH      (WIDTH),
        .DEFAULT_DIV(DEFAULT_DIV)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (en),
        .wr_en  (wr_en),
        .wr_ch  (wr_ch),
        .wr_data(wr_data),
`ifdef CLKDIV_PHASE_SYNC_EN
        .sync   (sync),
`endif
        .wr_err (wr_err),
        .clk_out(clk_out),
        .tick   (tick),
        .pending(pending)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Each channel is described by its output level and the number of clk
    // cycles left before the level must flip.
    int m_div      [CHANNELS];
    int m_left     [CHANNELS];
    int m_pend_div [CHANNELS];
    bit m_pend     [CHANNELS];
    bit m_level    [CHANNELS];
    bit m_tick     [CHANNELS];
    bit m_err;
    bit m_ok;
    bit m_sync;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CHANNELS; i++) begin
                m_div[i]   = DEFAULT_DIV;
                m_left[i]  = DEFAULT_DIV;
                m_pend[i]  = 1'b0;
                m_level[i] = 1'b0;
                m_tick[i]  = 1'b0;
            end
            m_err = 1'b0;
        end else begin
            m_ok  = wr_en && (int'(wr_ch) < CHANNELS) && (wr_data != 0);
            m_err = wr_en && !m_ok;
`ifdef CLKDIV_PHASE_SYNC_EN
            m_sync = sync;
`else
            m_sync = 1'b0;
`endif
            for (int i = 0; i < CHANNELS; i++) begin
                bit hit;
                hit = m_ok && (int'(wr_ch) == i);
                if (!en[i] || m_sync || m_left[i] == 1) begin
                    // New half-period starts now with the most recent divisor.
                    if (hit) m_div[i] = int'(wr_data);
                    else if (m_pend[i]) m_div[i] = m_pend_div[i];
                    m_pend[i] = 1'b0;
                    m_left[i] = m_div[i];
                    if (!en[i] || m_sync) begin
                        m_level[i] = 1'b0;
                        m_tick[i]  = 1'b0;
                    end else begin
                        m_level[i] = !m_level[i];
                        m_tick[i]  = m_level[i];
                    end
                end else begin
                    m_left[i] = m_left[i] - 1;
                    m_tick[i] = 1'b0;
                    if (hit) begin
                        m_pend[i]     = 1'b1;
                        m_pend_div[i] = int'(wr_data);
                    end
                end
            end
        end
    end

    // Compare every cycle while out of reset.
    always @(negedge clk) begin
        if (rst_n) begin
            logic [CHANNELS-1:0] e_clk, e_tick, e_pend;
            for (int i = 0; i < CHANNELS; i++) begin
                e_clk[i]  = m_level[i];
                e_tick[i] = m_tick[i];
                e_pend[i] = m_pend[i];
            end
            check("model clk_out", 64'(clk_out), 64'(e_clk));
            check("model tick",    64'(tick),    64'(e_tick));
            check("model pending", 64'(pending), 64'(e_pend));
            check("model wr_err",  64'(wr_err),  64'(m_err));
        end
    end

    // ---------------- helpers ----------------
    task automatic wait_tick(input int ch, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!tick[ch] && n <= BUDGET);
    endtask

    task automatic write(input int ch, input int data);
        wr_en   = 1'b1;
        wr_ch   = CH_W'(ch);
        wr_data = WIDTH'(data);
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        #12;
        check("reset clk_out", 64'(clk_out), 64'd0);
        check("reset tick",    64'(tick),    64'd0);
        check("reset pending", 64'(pending), 64'd0);
        check("reset wr_err",  64'(wr_err),  64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Default divisor 4: first rise 4 cycles after enable, then period 8.
        en = '1;
        wait_tick(0, n);
        check("first tick latency", 64'(n), 64'd4);
        wait_tick(0, n);
        check("tick period div4", 64'(n), 64'd8);

        // Write 2 to ch0 at cnt=1: pending, old half-period of 4 finishes.
        @(negedge clk);
        write(0, 2);
        check("pending after write", 64'(pending[0]), 64'd1);
        wait_tick(0, n);
        check("rise after pending switch", 64'(n), 64'd4);
        check("pending cleared", 64'(pending[0]), 64'd0);
        wait_tick(0, n);
        check("tick period div2", 64'(n), 64'd4);

        // Write 3 to ch1 exactly on its boundary: next half-period is 3.
        wait_tick(1, n);
        repeat (3) @(negedge clk);
        write(1, 3);
        check("boundary write no pending", 64'(pending[1]), 64'd0);
        check("boundary write falls", 64'(clk_out[1]), 64'd0);
        wait_tick(1, n);
        check("rise after boundary write", 64'(n), 64'd3);

        // Rejected writes: bad channel, then zero data.
        wr_en = 1'b1; wr_ch = 2'd3; wr_data = 16'd5;
        @(negedge clk);
        wr_en = 1'b0;
        check("wr_err bad channel", 64'(wr_err), 64'd1);
        @(negedge clk);
        check("wr_err one cycle", 64'(wr_err), 64'd0);
        write(2, 0);
        check("wr_err zero data", 64'(wr_err), 64'd1);
        wait_tick(2, n);
        wait_tick(2, n);
        check("ch2 period unchanged", 64'(n), 64'd8);

        // Disable ch0 mid-period, then re-enable: first rise after div=2.
        @(negedge clk);
        en[0] = 1'b0;
        @(negedge clk);
        check("disable clears clk_out", 64'(clk_out[0]), 64'd0);
        repeat (3) @(negedge clk);
        en[0] = 1'b1;
        wait_tick(0, n);
        check("re-enable latency", 64'(n), 64'd2);

`ifdef CLKDIV_PHASE_SYNC_EN
        // Two channels at divisors 4 and 6, out of phase, then sync.
        begin
            int t0, t1;
            en = '0;
            @(negedge clk);
            write(0, 4);
            write(1, 6);
            en[0] = 1'b1;
            repeat (3) @(negedge clk);
            en[1] = 1'b1;
            repeat (5) @(negedge clk);
            sync = 1'b1;
            @(negedge clk);
            sync = 1'b0;
            check("sync forces low", 64'(clk_out[1:0]), 64'd0);
            t0 = 0; t1 = 0;
            for (int c = 1; c <= 12; c++) begin
                @(negedge clk);
                if (tick[0] && t0 == 0) t0 = c;
                if (tick[1] && t1 == 0) t1 = c;
            end
            check("sync ch0 rise", 64'(t0), 64'd4);
            check("sync ch1 rise", 64'(t1), 64'd6);
        end
`endif

        // Randomized traffic checked by the model every cycle.
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            for (int i = 0; i < CHANNELS; i++)
                if ($urandom_range(0, 60) == 0) en[i] = ~en[i];
            wr_en   = ($urandom_range(0, 9) == 0);
            wr_ch   = CH_W'($urandom_range(0, 3));
            wr_data = WIDTH'($urandom_range(0, 6));
`ifdef CLKDIV_PHASE_SYNC_EN
            sync    = ($urandom_range(0, 80) == 0);
`endif
        end
        @(negedge clk);
        wr_en = 1'b0;
        en    = '1;
`ifdef CLKDIV_PHASE_SYNC_EN
        sync  = 1'b0;
`endif
        repeat (20) @(negedge clk);

        // Asynchronous reset between clock edges clears outputs at once.
        #2 rst_n = 1'b0;
        #1;
        check("async reset clk_out", 64'(clk_out), 64'd0);
        check("async reset tick",    64'(tick),    64'd0);
        check("async reset pending", 64'(pending), 64'd0);
        check("async reset wr_err",  64'(wr_err),  64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_tick(0, n);
        check("post reset latency", 64'(n), 64'd4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
